// File: rtl/dmem_lsu.sv
// Load/store unit between the MEM stage and four byte-wide data banks.
// Steers store bytes per lane, issues per-lane reads and extends the returned load data.
module dmem_lsu #(
    parameter int ADDR_WIDTH = 8
) (
    input  logic                          CLK,
    input  logic                          RST,
    input  logic                          REQ_VALID,
    output logic                          REQ_READY,
    input  logic                          REQ_WE,
    input  logic [2:0]                    REQ_FUNCT3,
    input  logic [ADDR_WIDTH-1:0]         REQ_ADDR,
    input  logic [31:0]                   REQ_WDATA,
    output logic                          RSP_VALID,
    input  logic                          RSP_READY,
    output logic [31:0]                   RSP_RDATA,
    output logic                          RSP_ERR,
    output logic [4*(ADDR_WIDTH-2)-1:0]   BANK_ADDR,
    output logic [3:0]                    BANK_WE,
    output logic [3:0]                    BANK_RE,
    output logic [31:0]                   BANK_DIN,
    input  logic [31:0]                   BANK_DOUT
);

    localparam int WW = ADDR_WIDTH - 2;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_HOLD = 2'd2
    } state_t;

    state_t        state_r;
    logic [1:0]    off_r;
    logic [2:0]    f3_r;
    logic [31:0]   hold_data_r;
    logic          hold_err_r;

    logic          req_ready_s;
    logic          accept_s;
    logic          legal_s;
    logic          load_acc_s;
    logic [1:0]    off_s;
    logic [WW-1:0] word_s;
    logic [WW-1:0] word_inc_s;
    logic [3:0]    lane_mask_s;
    logic [63:0]   din_rot_s;
    logic [63:0]   dout_rot_s;
    logic [31:0]   load_data_s;

    function automatic logic f3_legal(input logic [2:0] f3);
        case (f3)
            3'b000, 3'b001, 3'b010, 3'b100, 3'b101: return 1'b1;
            default:                                return 1'b0;
        endcase
    endfunction

    function automatic logic [3:0] size_mask(input logic [2:0] f3);
        case (f3[1:0])
            2'b00:   return 4'b0001;
            2'b01:   return 4'b0011;
            2'b10:   return 4'b1111;
            default: return 4'b0000;
        endcase
    endfunction

    // Circular left rotate of a 4-lane mask by the byte offset.
    function automatic logic [3:0] rotl_mask(input logic [3:0] m, input logic [1:0] o);
        logic [7:0] m2;
        m2 = {m, m} << o;
        return m2[7:4];
    endfunction

    assign req_ready_s = !RST && ((state_r == ST_IDLE) || ((state_r == ST_WAIT) && RSP_READY));
    assign accept_s    = REQ_VALID && req_ready_s;
    assign legal_s     = f3_legal(REQ_FUNCT3);
    assign load_acc_s  = accept_s && !REQ_WE;
    assign off_s       = REQ_ADDR[1:0];
    assign word_s      = REQ_ADDR[ADDR_WIDTH-1:2];
    assign word_inc_s  = word_s + {{(WW-1){1'b0}}, 1'b1};
    assign lane_mask_s = legal_s ? rotl_mask(size_mask(REQ_FUNCT3), off_s) : 4'b0000;
    assign din_rot_s   = {REQ_WDATA, REQ_WDATA} << {off_s, 3'b000};
    assign dout_rot_s  = {BANK_DOUT, BANK_DOUT} >> {off_r, 3'b000};

    assign REQ_READY = req_ready_s;
    assign BANK_DIN  = din_rot_s[63:32];
    assign RSP_VALID = (state_r != ST_IDLE);

    // Bank enables fire only in the acceptance cycle.
    always_comb begin
        BANK_WE = 4'b0000;
        BANK_RE = 4'b0000;
        if (accept_s) begin
            if (REQ_WE) begin
                BANK_WE = lane_mask_s;
            end else begin
                BANK_RE = lane_mask_s;
            end
        end else begin
            BANK_WE = 4'b0000;
            BANK_RE = 4'b0000;
        end
    end

    // Lanes below the offset that carry a used byte address the next word (wrapping).
    always_comb begin
        BANK_ADDR = '0;
        for (int i = 0; i < 4; i++) begin
            if (lane_mask_s[i] && (i < int'(off_s))) begin
                BANK_ADDR[i*WW +: WW] = word_inc_s;
            end else begin
                BANK_ADDR[i*WW +: WW] = word_s;
            end
        end
    end

    // Sign/zero extension of the rotated bank data; illegal funct3 yields zero.
    always_comb begin
        load_data_s = 32'h0000_0000;
        case (f3_r)
            3'b000:  load_data_s = {{24{dout_rot_s[7]}}, dout_rot_s[7:0]};
            3'b001:  load_data_s = {{16{dout_rot_s[15]}}, dout_rot_s[15:0]};
            3'b010:  load_data_s = dout_rot_s[31:0];
            3'b100:  load_data_s = {24'h00_0000, dout_rot_s[7:0]};
            3'b101:  load_data_s = {16'h0000, dout_rot_s[15:0]};
            default: load_data_s = 32'h0000_0000;
        endcase
    end

    // Response mux: live bank data while waiting, captured copy while held.
    always_comb begin
        RSP_RDATA = 32'h0000_0000;
        RSP_ERR   = 1'b0;
        case (state_r)
            ST_WAIT: begin
                RSP_RDATA = load_data_s;
                RSP_ERR   = !f3_legal(f3_r);
            end
            ST_HOLD: begin
                RSP_RDATA = hold_data_r;
                RSP_ERR   = hold_err_r;
            end
            default: begin
                RSP_RDATA = 32'h0000_0000;
                RSP_ERR   = 1'b0;
            end
        endcase
    end

    // Response FSM: capture load attributes, hold the result under backpressure.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_r     <= ST_IDLE;
            off_r       <= 2'b00;
            f3_r        <= 3'b000;
            hold_data_r <= 32'h0000_0000;
            hold_err_r  <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (load_acc_s) begin
                        state_r <= ST_WAIT;
                        off_r   <= off_s;
                        f3_r    <= REQ_FUNCT3;
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_WAIT: begin
                    if (RSP_READY) begin
                        if (load_acc_s) begin
                            state_r <= ST_WAIT;
                            off_r   <= off_s;
                            f3_r    <= REQ_FUNCT3;
                        end else begin
                            state_r <= ST_IDLE;
                        end
                    end else begin
                        state_r     <= ST_HOLD;
                        hold_data_r <= load_data_s;
                        hold_err_r  <= !f3_legal(f3_r);
                    end
                end
                ST_HOLD: begin
                    if (RSP_READY) begin
                        state_r <= ST_IDLE;
                    end else begin
                        state_r <= ST_HOLD;
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dmem_lsu.sv
// Bench for dmem_lsu: bank memory model plus a flat byte-array reference of loads and stores.
module tb_dmem_lsu;

    localparam int AW = 8;
    localparam int WW = AW - 2;

    logic            CLK = 1'b0;
    logic            RST;
    logic            REQ_VALID;
    logic            REQ_READY;
    logic            REQ_WE;
    logic [2:0]      REQ_FUNCT3;
    logic [AW-1:0]   REQ_ADDR;
    logic [31:0]     REQ_WDATA;
    logic            RSP_VALID;
    logic            RSP_READY;
    logic [31:0]     RSP_RDATA;
    logic            RSP_ERR;
    logic [4*WW-1:0] BANK_ADDR;
    logic [3:0]      BANK_WE;
    logic [3:0]      BANK_RE;
    logic [31:0]     BANK_DIN;
    logic [31:0]     BANK_DOUT;

    always #5 CLK = ~CLK;

    dmem_lsu #(.ADDR_WIDTH(AW)) dut (
        .CLK(CLK), .RST(RST),
        .REQ_VALID(REQ_VALID), .REQ_READY(REQ_READY), .REQ_WE(REQ_WE),
        .REQ_FUNCT3(REQ_FUNCT3), .REQ_ADDR(REQ_ADDR), .REQ_WDATA(REQ_WDATA),
        .RSP_VALID(RSP_VALID), .RSP_READY(RSP_READY), .RSP_RDATA(RSP_RDATA), .RSP_ERR(RSP_ERR),
        .BANK_ADDR(BANK_ADDR), .BANK_WE(BANK_WE), .BANK_RE(BANK_RE),
        .BANK_DIN(BANK_DIN), .BANK_DOUT(BANK_DOUT)
    );

    // Four byte-wide banks with registered read data.
    logic [7:0] bank_mem [4][64];
    logic [7:0] dout_b [4];

    initial begin
        for (int i = 0; i < 4; i++) begin
            dout_b[i] = 8'h00;
            for (int j = 0; j < 64; j++) bank_mem[i][j] = 8'h00;
        end
    end

    always @(posedge CLK) begin
        for (int i = 0; i < 4; i++) begin
            if (BANK_WE[i]) bank_mem[i][BANK_ADDR[i*WW +: WW]] <= BANK_DIN[8*i +: 8];
            if (BANK_RE[i]) dout_b[i] <= bank_mem[i][BANK_ADDR[i*WW +: WW]];
        end
    end

    assign BANK_DOUT = {dout_b[3], dout_b[2], dout_b[1], dout_b[0]};

    // Reference model: flat byte memory and queue of expected responses.
    typedef struct packed {
        logic [31:0] data;
        logic        err;
    } rsp_t;

    logic [7:0] ref_mem [256];
    rsp_t       exp_q [$];
    bit         fresh = 1'b0;
    int         checks = 0;
    int         passes = 0;
    logic [2:0] legal_tab [5] = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101};

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    function automatic int nbytes(input logic [2:0] f3);
        case (f3)
            3'b000, 3'b100: return 1;
            3'b001, 3'b101: return 2;
            3'b010:         return 4;
            default:        return 0;
        endcase
    endfunction

    function automatic rsp_t ref_load(input logic [2:0] f3, input logic [7:0] addr);
        rsp_t r;
        int n;
        logic [31:0] v;
        n = nbytes(f3);
        if (n == 0) begin
            r.data = 32'h0000_0000;
            r.err  = 1'b1;
            return r;
        end
        v = 32'h0000_0000;
        for (int k = 0; k < n; k++) v[8*k +: 8] = ref_mem[(int'(addr) + k) & 255];
        if (!f3[2] && n < 4 && v[8*n-1]) v = v | (32'hFFFF_FFFF << (8*n));
        r.data = v;
        r.err  = 1'b0;
        return r;
    endfunction

    // One clock cycle: drive at the falling edge, check, then advance the model.
    task automatic drive_cycle(input logic v, input logic we, input logic [2:0] f3,
                               input logic [7:0] addr, input logic [31:0] wd,
                               input logic rr, output bit acc);
        bit          exp_rdy;
        int          n;
        int          a;
        int          lane;
        logic [3:0]  we_m;
        logic [3:0]  re_m;
        logic [31:0] din_e;
        logic [31:0] din_m;
        logic [4*WW-1:0] ba_e;
        @(negedge CLK);
        REQ_VALID  = v;
        REQ_WE     = we;
        REQ_FUNCT3 = f3;
        REQ_ADDR   = addr;
        REQ_WDATA  = wd;
        RSP_READY  = rr;
        #1;
        if (exp_q.size() > 0) begin
            chk("rsp_valid", {31'b0, RSP_VALID}, 32'd1);
            chk("rsp_rdata", RSP_RDATA, exp_q[0].data);
            chk("rsp_err", {31'b0, RSP_ERR}, {31'b0, exp_q[0].err});
        end else begin
            chk("rsp_idle", {31'b0, RSP_VALID}, 32'd0);
        end
        exp_rdy = (exp_q.size() == 0) || (fresh && rr);
        chk("req_ready", {31'b0, REQ_READY}, {31'b0, exp_rdy});
        acc   = v && exp_rdy;
        n     = nbytes(f3);
        we_m  = 4'b0000;
        re_m  = 4'b0000;
        din_e = 32'h0000_0000;
        din_m = 32'h0000_0000;
        for (int i = 0; i < 4; i++) ba_e[i*WW +: WW] = addr[7:2];
        for (int k = 0; k < n; k++) begin
            a    = (int'(addr) + k) & 255;
            lane = a & 3;
            ba_e[lane*WW +: WW] = 6'(a >> 2);
            if (acc && we) begin
                we_m[lane] = 1'b1;
                din_e[8*lane +: 8] = wd[8*k +: 8];
                din_m[8*lane +: 8] = 8'hFF;
            end else if (acc) begin
                re_m[lane] = 1'b1;
            end
        end
        chk("bank_we", {28'b0, BANK_WE}, {28'b0, we_m});
        chk("bank_re", {28'b0, BANK_RE}, {28'b0, re_m});
        chk("bank_addr", {8'b0, BANK_ADDR}, {8'b0, ba_e});
        if (acc && we && n > 0) chk("bank_din", BANK_DIN & din_m, din_e);
        if (exp_q.size() > 0 && rr) void'(exp_q.pop_front());
        if (acc && !we) exp_q.push_back(ref_load(f3, addr));
        if (acc && we) begin
            for (int k = 0; k < n; k++) ref_mem[(int'(addr) + k) & 255] = wd[8*k +: 8];
        end
        fresh = acc && !we;
    endtask

    task automatic issue(input logic we, input logic [2:0] f3, input logic [7:0] addr,
                         input logic [31:0] wd);
        bit acc;
        for (int t = 0; t < 8; t++) begin
            drive_cycle(1'b1, we, f3, addr, wd, 1'b1, acc);
            if (acc) return;
        end
        checks++;
        $error("FAIL issue_timeout observed=not_accepted expected=accepted addr=%h", addr);
    endtask

    task automatic idle(input int cycles);
        bit acc;
        for (int t = 0; t < cycles; t++) drive_cycle(1'b0, 1'b0, 3'b000, 8'h00, 32'h0, 1'b1, acc);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bit acc;
        for (int i = 0; i < 256; i++) ref_mem[i] = 8'h00;
        RST        = 1'b1;
        REQ_VALID  = 1'b1;
        REQ_WE     = 1'b0;
        REQ_FUNCT3 = 3'b010;
        REQ_ADDR   = 8'h08;
        REQ_WDATA  = 32'h0;
        RSP_READY  = 1'b1;
        repeat (2) @(posedge CLK);
        @(negedge CLK);
        #1;
        chk("rst_rsp_valid", {31'b0, RSP_VALID}, 32'd0);
        chk("rst_req_ready", {31'b0, REQ_READY}, 32'd0);
        chk("rst_bank_re", {28'b0, BANK_RE}, 32'd0);
        chk("rst_bank_we", {28'b0, BANK_WE}, 32'd0);
        chk("rst_rdata", RSP_RDATA, 32'd0);
        chk("rst_err", {31'b0, RSP_ERR}, 32'd0);
        @(negedge CLK);
        RST       = 1'b0;
        REQ_VALID = 1'b0;
        #1;
        chk("ready_after_rst", {31'b0, REQ_READY}, 32'd1);

        // Word store/load round trip.
        issue(1'b1, 3'b010, 8'h08, 32'h1122_3344);
        issue(1'b0, 3'b010, 8'h08, 32'h0);
        idle(1);
        // Byte store, signed and unsigned byte loads.
        issue(1'b1, 3'b000, 8'h05, 32'h0000_00AB);
        issue(1'b0, 3'b000, 8'h05, 32'h0);
        issue(1'b0, 3'b100, 8'h05, 32'h0);
        idle(1);
        // Misaligned word at the top of memory wraps lane 0 to word 0.
        issue(1'b1, 3'b010, 8'hFD, 32'hCAFE_BABE);
        issue(1'b0, 3'b010, 8'hFD, 32'h0);
        issue(1'b0, 3'b101, 8'hFF, 32'h0);
        idle(1);
        // Backpressure: three loads, consumer stalls for two cycles.
        drive_cycle(1'b1, 1'b0, 3'b010, 8'h08, 32'h0, 1'b1, acc);
        drive_cycle(1'b1, 1'b0, 3'b010, 8'hFD, 32'h0, 1'b0, acc);
        drive_cycle(1'b1, 1'b0, 3'b010, 8'hFD, 32'h0, 1'b0, acc);
        issue(1'b0, 3'b010, 8'hFD, 32'h0);
        issue(1'b0, 3'b000, 8'h05, 32'h0);
        idle(2);
        // Illegal funct3: erroring load, dropped store.
        issue(1'b0, 3'b011, 8'h08, 32'h0);
        idle(1);
        issue(1'b1, 3'b111, 8'h08, 32'hDEAD_BEEF);
        issue(1'b0, 3'b010, 8'h08, 32'h0);
        idle(1);
        // Reset while a result is in flight.
        issue(1'b0, 3'b010, 8'h08, 32'h0);
        @(negedge CLK);
        REQ_VALID = 1'b0;
        RST       = 1'b1;
        #1;
        chk("midrst_rsp_valid", {31'b0, RSP_VALID}, 32'd0);
        chk("midrst_req_ready", {31'b0, REQ_READY}, 32'd0);
        exp_q.delete();
        fresh = 1'b0;
        @(negedge CLK);
        RST = 1'b0;
        #1;
        chk("postrst_ready", {31'b0, REQ_READY}, 32'd1);
        chk("postrst_valid", {31'b0, RSP_VALID}, 32'd0);
        idle(1);

        // Randomized traffic around the wrap boundary.
        for (int it = 0; it < 400; it++) begin
            logic [2:0] f3;
            logic [7:0] addr;
            f3   = ($urandom % 6 == 0) ? 3'($urandom) : legal_tab[$urandom % 5];
            addr = {(($urandom % 2) == 0) ? 4'hF : 4'h0, 4'($urandom)};
            drive_cycle(($urandom % 4) != 0, ($urandom % 2) == 0, f3, addr, $urandom,
                        ($urandom % 4) != 0, acc);
        end
        idle(3);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
